// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and the control decoder.
// The pc_source codes here are the contract between decoder and fetch.
package cpu_pkg;

   localparam logic [2:0] PCS_SEQ  = 3'b000;
   localparam logic [2:0] PCS_BEQ  = 3'b001;
   localparam logic [2:0] PCS_BNE  = 3'b010;
   localparam logic [2:0] PCS_BLT  = 3'b011;
   localparam logic [2:0] PCS_BGE  = 3'b100;
   localparam logic [2:0] PCS_JAL  = 3'b101;
   localparam logic [2:0] PCS_JALR = 3'b110;

   // addi x0,x0,0 : what decode sees whenever no real instruction is held
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH_REQ,
      FETCH_WAIT,
      FETCH_EXEC,
      FETCH_TRAP
   } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection: turns the decoder's pc_source code and the ALU flags
// into the address of the next instruction, and flags targets that are not
// word aligned. Purely combinational.
module next_pc_sel
   import cpu_pkg::*;
(
   input  logic [31:0] i_pc,
   input  logic [31:0] i_imm,
   input  logic [31:0] i_jalrTarget,
   input  logic [2:0]  i_pcSource,
   input  logic        i_aluZero,
   input  logic        i_aluLastBit,
   output logic [31:0] o_nextPc,
   output logic        o_misaligned
);

   logic [31:0] w_seqPc;
   logic [31:0] w_relPc;
   logic [31:0] w_nextPc;

   assign w_seqPc = i_pc + 32'd4;
   assign w_relPc = i_pc + i_imm;

   // Branches pick between the relative target and fall-through; JALR drops bit 0
   always_comb begin
      w_nextPc = w_seqPc;
      case (i_pcSource)
         PCS_SEQ:  w_nextPc = w_seqPc;
         PCS_BEQ:  w_nextPc = i_aluZero     ? w_relPc : w_seqPc;
         PCS_BNE:  w_nextPc = !i_aluZero    ? w_relPc : w_seqPc;
         PCS_BLT:  w_nextPc = i_aluLastBit  ? w_relPc : w_seqPc;
         PCS_BGE:  w_nextPc = !i_aluLastBit ? w_relPc : w_seqPc;
         PCS_JAL:  w_nextPc = w_relPc;
         PCS_JALR: w_nextPc = i_jalrTarget & ~32'h1;
         default:  w_nextPc = w_seqPc;
      endcase
   end

   assign o_nextPc     = w_nextPc;
   assign o_misaligned = (w_nextPc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests words from instruction
// memory, holds the current instruction for decode and advances the PC when
// the core retires. A misaligned target parks the stage in TRAP until reset.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        retire,
   input  logic [2:0]  pc_source,
   input  logic [31:0] imm,
   input  logic        alu_zero,
   input  logic        alu_last_bit,
   input  logic [31:0] jalr_target,
   output logic        fetch_trap,
   output logic [31:0] instret
);

   import cpu_pkg::*;

   fetch_state_t r_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_instr;
   logic         r_instrValid;
   logic         r_fetchTrap;
   logic [31:0]  r_instret;
   logic         r_reqValid;

   logic [31:0]  w_nextPc;
   logic         w_misaligned;

   next_pc_sel u_nextPcSel (
      .i_pc         (r_pc),
      .i_imm        (imm),
      .i_jalrTarget (jalr_target),
      .i_pcSource   (pc_source),
      .i_aluZero    (alu_zero),
      .i_aluLastBit (alu_last_bit),
      .o_nextPc     (w_nextPc),
      .o_misaligned (w_misaligned)
   );

   // Fetch sequencer: request, wait for the word, execute until retire, or trap
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= FETCH_REQ;
         r_pc         <= RESET_PC;
         r_instr      <= NOP_INSTR;
         r_instrValid <= 1'b0;
         r_fetchTrap  <= 1'b0;
         r_instret    <= 32'd0;
         r_reqValid   <= 1'b0;
      end else begin
         case (r_state)
            FETCH_REQ: begin
               if (!r_reqValid) begin
                  r_reqValid <= 1'b1;
               end else if (imem_req_ready) begin
                  r_reqValid <= 1'b0;
                  r_state    <= FETCH_WAIT;
               end
            end
            FETCH_WAIT: begin
               if (imem_rsp_valid) begin
                  r_instr      <= imem_rsp_data;
                  r_instrValid <= 1'b1;
                  r_state      <= FETCH_EXEC;
               end
            end
            FETCH_EXEC: begin
               if (retire) begin
                  r_instret    <= r_instret + 32'd1;
                  r_instr      <= NOP_INSTR;
                  r_instrValid <= 1'b0;
                  if (w_misaligned) begin
                     r_fetchTrap <= 1'b1;
                     r_state     <= FETCH_TRAP;
                  end else begin
                     r_pc       <= w_nextPc;
                     r_reqValid <= 1'b1;
                     r_state    <= FETCH_REQ;
                  end
               end
            end
            FETCH_TRAP: begin
               r_reqValid   <= 1'b0;
               r_instrValid <= 1'b0;
               r_instr      <= NOP_INSTR;
            end
            default: begin
               r_state <= FETCH_TRAP;
            end
         endcase
      end
   end

   assign imem_req_valid = r_reqValid;
   assign imem_addr      = r_pc;
   assign pc             = r_pc;
   assign pc_plus4       = r_pc + 32'd4;
   assign instr          = r_instr;
   assign instr_valid    = r_instrValid;
   assign fetch_trap     = r_fetchTrap;
   assign instret        = r_instret;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the control decoder.
- Holds the PC and issues requests to instruction memory over a valid/ready request and valid response handshake.
- Latches the returned word into an instruction register that drives op/func3/func7 decode.
- On each retire, computes the next PC from the decoder's pc_source code plus ALU flags.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction register value whenever no valid instruction is held (addi x0,x0,0).

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_addr  output  32  fetch address; equals pc.
- imem_rsp_valid  input  1  response data valid.
- imem_rsp_data  input  32  fetched instruction word.
- instr  output  32  held instruction, feeds decode.
- instr_valid  output  1  instr is valid and executing.
- pc  output  32  current PC.
- pc_plus4  output  32  pc+4, the link value.
- retire  input  1  core finished the current instruction.
- pc_source  input  3  decoder code: 000 seq, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 JAL, 110 JALR, 111 seq.
- imm  input  32  sign-extended immediate (B/J offset).
- alu_zero  input  1  ALU result zero.
- alu_last_bit  input  1  ALU result bit 31 (sign of rs1-rs2).
- jalr_target  input  32  rs1+imm from the ALU.
- fetch_trap  output  1  misaligned target detected; sticky.
- instret  output  32  retired-instruction count, wraps.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=REQ, pc=RESET_PC, instr=NOP_INSTR, instr_valid=0, fetch_trap=0, instret=0, imem_req_valid=0 while rst is high.
  - Reset mid-operation aborts any outstanding request.
  - The cycle after rst falls, imem_req_valid=1.
- States: REQ, WAIT, EXEC, TRAP.
- REQ:
  - imem_req_valid=1, imem_addr=pc.
  - req_valid && req_ready -> WAIT.
  - req_valid stays high and imem_addr stays stable until accepted.
- WAIT:
  - imem_rsp_valid=1 -> instr<=imem_rsp_data, instr_valid<=1, -> EXEC.
  - Otherwise hold.
- EXEC:
  - instr_valid=1; instr and pc stay constant.
  - retire=1 -> pc<=next_pc, instret<=instret+1, instr<=NOP_INSTR, instr_valid<=0, -> REQ.
  - If next_pc[1:0]!=0, instead -> TRAP, leaving pc unchanged and instret incremented.
- TRAP:
  - fetch_trap=1, no requests, instr=NOP_INSTR, instr_valid=0.
  - Exit only via rst.
- next_pc (combinational, 32-bit wrap-around arithmetic):
  - 001 BEQ: taken if alu_zero.
  - 010 BNE: taken if !alu_zero.
  - 011 BLT: taken if alu_last_bit.
  - 100 BGE: taken if !alu_last_bit.
  - Taken branch -> pc+imm; not taken -> pc+4.
  - 101 JAL -> pc+imm.
  - 110 JALR -> jalr_target & ~32'h1.
  - 000/111 -> pc+4.
- Minimum latency per instruction: REQ accept (1) + response (>=1) + EXEC (>=1) = 3 cycles.
- Ignored inputs:
  - imem_rsp_valid outside WAIT (stale or unsolicited) is ignored.
  - retire outside EXEC is ignored.
- Simultaneous rst with retire or rsp_valid: rst wins.
- pc_plus4 is always pc+4; at pc=32'hFFFF_FFFC it wraps to 0.
- instret wraps from 32'hFFFF_FFFF to 0.

Decomposition:
- Shared package cpu_pkg holds:
  - pc_source encodings as named constants (PCS_SEQ, PCS_BEQ, PCS_BNE, PCS_BLT, PCS_BGE, PCS_JAL, PCS_JALR).
  - NOP_INSTR constant.
  - fetch state enum.
- The control decoder is updated to use these same constants.
- One sub-module, next_pc_sel: purely combinational evaluation of pc, imm, flags, pc_source and jalr_target into next_pc plus a misaligned flag.

Test Plan:
- Reset then memory with 1-cycle ready and response, pc_source=000 retire each instr -> imem_addr sequence 0,4,8; instret=3; instr_valid low between instructions.
- BEQ at pc=0x10, imm=0x20: alu_zero=1 -> next fetch 0x30; alu_zero=0 -> next fetch 0x14.
- BLT/BGE at pc=0x40, imm=-8 (0xFFFF_FFF8) with alu_last_bit=1 -> BLT fetches 0x38, BGE fetches 0x44.
- JALR with jalr_target=0x0000_0105 -> fetch 0x104. JAL at pc=0x100, imm=0x6 -> fetch_trap=1, pc stays 0x100, no further req_valid.
- imem_req_ready held low 5 cycles, then response delayed 3 cycles with a spurious rsp_valid during REQ -> imem_addr stable throughout, spurious word not latched, correct word latched.
- rst asserted in WAIT and again in EXEC with retire=1 -> pc=RESET_PC, instr=0x0000_0013, instret=0, state REQ, rst wins.
